uart_loader: RTL and testbench

//  Boot-load sequencer sitting downstream of uart_rx: consumes received bytes, parses a

---
 rtl/uart_loader_if.sv | 26 ++
 rtl/uart_loader.sv | 214 +++++++++++++++++++++
 tb/tb_uart_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
// Byte-in / word-out bus of the boot loader.
// master: the loader (consumes uart_rx bytes, drives the memory write port and status).
// slave:  the surrounding system (uart_rx, memory, CPU reset control).
interface uart_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              mem_we;
  logic              cpu_hold;
  logic              loading;
  logic              done;
  logic              err;

  modport master (
    input  rx_data, rx_ready,
    output mem_addr, mem_data, mem_we, cpu_hold, loading, done, err
  );

  modport slave (
    output rx_data, rx_ready,
    input  mem_addr, mem_data, mem_we, cpu_hold, loading, done, err
  );
endinterface

// File: rtl/uart_loader.sv
// uart_loader: boot-load sequencer downstream of uart_rx.
// Parses MAGIC, LEN_HI, LEN_LO, LEN x {HI, LO} [, CSUM] and writes each word to memory,
// holding the CPU in reset while loading and releasing it only after a good frame.
// Optional feature macro: UART_LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for MAGIC, other bytes ignored
// S_LEN_HI  | waiting for length high byte
// S_LEN_LO  | waiting for length low byte
// S_DATA_HI | waiting for word high byte (or consuming a pending byte)
// S_DATA_LO | waiting for word low byte
// S_WRITE   | issue the one-cycle write strobe, count the word
// S_CSUM    | waiting for checksum byte (checksum build only)
// S_DONE    | frame good: flag done, release CPU
// S_ERR     | frame aborted: flag err, CPU stays held
module uart_loader #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [7:0]        MAGIC        = 8'hA5,
  parameter int                TIMEOUT_CLKS = 500000
) (
  input  logic          clk,
  input  logic          rst,
  uart_loader_if.master bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;
  // Where the frame goes once the last word (or a zero length) has been handled.
  localparam state_t S_AFTER = S_CSUM;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_DONE, S_ERR
  } state_t;
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t            state;
  logic              rx_ready_q;
  logic              pending;
  logic [7:0]        pend_data;
  logic [7:0]        len_hi;
  logic [7:0]        byte_hi;
  logic [15:0]       word_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_data_q;
  logic              mem_we_q;
  logic              cpu_hold_q;
  logic              loading_q;
  logic              done_q;
  logic              err_q;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic       strobe;
  logic       in_frame;
  logic       tmo_hit;
  logic       hi_avail;
  logic [7:0] hi_byte;
  logic [15:0] len_word;

  // Byte strobe, frame-state decode and the source of the next high byte.
  always_comb begin
    strobe   = bus.rx_ready & ~rx_ready_q;
    in_frame = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
               (state == S_DATA_LO) || (state == S_WRITE)
`ifdef UART_LOADER_CHECKSUM_EN
               || (state == S_CSUM)
`endif
               ;
    tmo_hit  = in_frame && (tmo_cnt == TMO_W'(TIMEOUT_CLKS));
    hi_avail = pending | strobe;
    hi_byte  = pending ? pend_data : bus.rx_data;
    len_word = {len_hi, bus.rx_data};
  end

  // Frame parser, inter-byte timer and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rx_ready_q <= 1'b0;
      pending    <= 1'b0;
      pend_data  <= 8'h00;
      len_hi     <= 8'h00;
      byte_hi    <= 8'h00;
      word_cnt   <= 16'h0000;
      tmo_cnt    <= '0;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= 16'h0000;
      mem_we_q   <= 1'b0;
      cpu_hold_q <= 1'b0;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      rx_ready_q <= bus.rx_ready;
      mem_we_q   <= 1'b0;
      // The address advances in the cycle after the strobe, so it is stable during it.
      if (mem_we_q) mem_addr_q <= mem_addr_q + ADDR_W'(1);

      if ((state == S_IDLE) || strobe) tmo_cnt <= '0;
      else if (in_frame)               tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (tmo_hit) begin
        state   <= S_ERR;
        pending <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            pending <= 1'b0;
            if (strobe && (bus.rx_data == MAGIC)) begin
              state      <= S_LEN_HI;
              done_q     <= 1'b0;
              err_q      <= 1'b0;
              loading_q  <= 1'b1;
              cpu_hold_q <= 1'b1;
              mem_addr_q <= BASE_ADDR;
`ifdef UART_LOADER_CHECKSUM_EN
              csum_q     <= 8'h00;
`endif
            end
          end
          S_LEN_HI: begin
            if (strobe) begin
              len_hi <= bus.rx_data;
`ifdef UART_LOADER_CHECKSUM_EN
              csum_q <= csum_q ^ bus.rx_data;
`endif
              state  <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (strobe) begin
              word_cnt <= len_word;
`ifdef UART_LOADER_CHECKSUM_EN
              csum_q   <= csum_q ^ bus.rx_data;
`endif
              state    <= (len_word == 16'h0000) ? S_AFTER : S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            if (hi_avail) begin
              byte_hi <= hi_byte;
              pending <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
              csum_q  <= csum_q ^ hi_byte;
`endif
              state   <= S_DATA_LO;
            end
          end
          S_DATA_LO: begin
            if (strobe) begin
              mem_data_q <= {byte_hi, bus.rx_data};
`ifdef UART_LOADER_CHECKSUM_EN
              csum_q     <= csum_q ^ bus.rx_data;
`endif
              state      <= S_WRITE;
            end
          end
          S_WRITE: begin
            mem_we_q <= 1'b1;
            word_cnt <= word_cnt - 16'h0001;
            // A byte landing here belongs to the next word; park it instead of losing it.
            if (strobe) begin
              pending   <= 1'b1;
              pend_data <= bus.rx_data;
            end
            state <= (word_cnt == 16'h0001) ? S_AFTER : S_DATA_HI;
          end
`ifdef UART_LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (hi_avail) begin
              pending <= 1'b0;
              state   <= (hi_byte == csum_q) ? S_DONE : S_ERR;
            end
          end
`endif
          S_DONE: begin
            done_q     <= 1'b1;
            loading_q  <= 1'b0;
            cpu_hold_q <= 1'b0;
            state      <= S_IDLE;
          end
          S_ERR: begin
            err_q     <= 1'b1;
            loading_q <= 1'b0;
            pending   <= 1'b0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.loading  = loading_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: two instances share the byte stream, one loading at
// 16'h0000 and one at 16'hFFFF to exercise address wrap.
module tb_uart_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_loader_if #(.ADDR_W(16)) bus_a ();
  uart_loader_if #(.ADDR_W(16)) bus_b ();

  assign bus_b.rx_data  = bus_a.rx_data;
  assign bus_b.rx_ready = bus_a.rx_ready;

  uart_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000), .MAGIC(8'hA5), .TIMEOUT_CLKS(200)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  uart_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFF), .MAGIC(8'hA5), .TIMEOUT_CLKS(200)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wa[$];
  logic [31:0] wb[$];

  // Log every write as {addr, data}; a one-cycle pulse is seen on exactly one negedge.
  always @(negedge clk) begin
    if (bus_a.mem_we) wa.push_back({bus_a.mem_addr, bus_a.mem_data});
    if (bus_b.mem_we) wb.push_back({bus_b.mem_addr, bus_b.mem_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus_a.rx_data  = b;
    bus_a.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus_a.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    bus_a.rx_data  = 8'h00;
    bus_a.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr",    32'(bus_a.mem_addr), 32'h0000);
    check("rst_addr_b",  32'(bus_b.mem_addr), 32'hFFFF);
    check("rst_data",    32'(bus_a.mem_data), 32'h0);
    check("rst_we",      32'(bus_a.mem_we),   32'h0);
    check("rst_hold",    32'(bus_a.cpu_hold), 32'h0);
    check("rst_loading", 32'(bus_a.loading),  32'h0);
    check("rst_done",    32'(bus_a.done),     32'h0);
    check("rst_err",     32'(bus_a.err),      32'h0);
    rst = 1'b1;

    // Bytes before MAGIC are ignored, then MAGIC opens the frame.
    send_byte(8'h00);
    send_byte(8'h12);
    check("pre_loading", 32'(bus_a.loading),  32'h0);
    check("pre_hold",    32'(bus_a.cpu_hold), 32'h0);
    send_byte(8'hA5);
    check("magic_loading", 32'(bus_a.loading),  32'h1);
    check("magic_hold",    32'(bus_a.cpu_hold), 32'h1);

    // LEN=2: 1234, ABCD. The last LO byte is driven inline to pin down write latency.
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    @(negedge clk);
    bus_a.rx_data  = 8'hCD;
    bus_a.rx_ready = 1'b1;
    @(negedge clk);
    check("we_lat_1clk", 32'(bus_a.mem_we), 32'h0);
    @(negedge clk);
    check("we_lat_2clk", 32'(bus_a.mem_we), 32'h1);
    bus_a.rx_ready = 1'b0;
    @(negedge clk);
    check("we_pulse_end", 32'(bus_a.mem_we), 32'h0);
    @(negedge clk);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'h42);  // 00^02^12^34^AB^CD
`endif
    repeat (3) @(negedge clk);
    check("t2_writes",  32'(wa.size()), 32'd2);
    check("t2_w0",      wa[0], {16'h0000, 16'h1234});
    check("t2_w1",      wa[1], {16'h0001, 16'hABCD});
    check("t2_done",    32'(bus_a.done),     32'h1);
    check("t2_err",     32'(bus_a.err),      32'h0);
    check("t2_hold",    32'(bus_a.cpu_hold), 32'h0);
    check("t2_loading", 32'(bus_a.loading),  32'h0);
    check("t2_addr",    32'(bus_a.mem_addr), 32'h0002);
    check("wrap_writes", 32'(wb.size()), 32'd2);
    check("wrap_w0",     wb[0], {16'hFFFF, 16'h1234});
    check("wrap_w1",     wb[1], {16'h0000, 16'hABCD});

    // Zero-length frame: no writes, done again; MAGIC clears the old done first.
    wa.delete();
    wb.delete();
    send_byte(8'hA5);
    check("len0_done_clr", 32'(bus_a.done),     32'h0);
    check("len0_addr",     32'(bus_a.mem_addr), 32'h0000);
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    repeat (3) @(negedge clk);
    check("len0_writes", 32'(wa.size()), 32'd0);
    check("len0_done",   32'(bus_a.done),     32'h1);
    check("len0_hold",   32'(bus_a.cpu_hold), 32'h0);

    // MAGIC inside the frame is plain data.
    wa.delete();
    wb.delete();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hA5);
    send_byte(8'h5A);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'hFE);  // 00^01^A5^5A
`endif
    repeat (3) @(negedge clk);
    check("magicdata_writes", 32'(wa.size()), 32'd1);
    check("magicdata_w0",     wa[0], {16'h0000, 16'hA55A});
    check("magicdata_done",   32'(bus_a.done), 32'h1);

    // Silence after a HI byte: timeout aborts, CPU stays held, nothing written.
    wa.delete();
    wb.delete();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (150) @(negedge clk);
    check("tmo_not_yet", 32'(bus_a.loading), 32'h1);
    check("tmo_no_err",  32'(bus_a.err),     32'h0);
    repeat (100) @(negedge clk);
    check("tmo_err",     32'(bus_a.err),      32'h1);
    check("tmo_done",    32'(bus_a.done),     32'h0);
    check("tmo_hold",    32'(bus_a.cpu_hold), 32'h1);
    check("tmo_loading", 32'(bus_a.loading),  32'h0);
    check("tmo_writes",  32'(wa.size()),      32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
    // Bad checksum: words stay written, frame flagged as error.
    wa.delete();
    wb.delete();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    check("csum_writes", 32'(wa.size()), 32'd2);
    check("csum_err",    32'(bus_a.err),      32'h1);
    check("csum_done",   32'(bus_a.done),     32'h0);
    check("csum_hold",   32'(bus_a.cpu_hold), 32'h1);
`endif

    // Reset mid-frame, asserted between clock edges, then a good frame.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    #3;
    rst = 1'b0;
    #1;
    check("arst_loading", 32'(bus_a.loading),  32'h0);
    check("arst_hold",    32'(bus_a.cpu_hold), 32'h0);
    check("arst_addr",    32'(bus_a.mem_addr), 32'h0000);
    check("arst_err",     32'(bus_a.err),      32'h0);
    check("arst_we",      32'(bus_a.mem_we),   32'h0);
    @(negedge clk);
    wa.delete();
    wb.delete();
    rst = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hBE);
    send_byte(8'hEF);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'h50);  // 00^01^BE^EF
`endif
    repeat (3) @(negedge clk);
    check("post_rst_writes", 32'(wa.size()), 32'd1);
    check("post_rst_w0",     wa[0], {16'h0000, 16'hBEEF});
    check("post_rst_done",   32'(bus_a.done),     32'h1);
    check("post_rst_hold",   32'(bus_a.cpu_hold), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
